// File: rtl/nibble_serializer_pkg.sv
// Shared definitions for the nibble serializer: FSM state encoding and
// width helpers used to size counters and FIFO pointers.
package nibble_serializer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Bits needed for a counter running 0..value-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned value);
    return (value > 1) ? clog2(value) : 1;
  endfunction

endpackage

// File: rtl/nibble_serializer_sync_fifo.sv
// Synchronous FIFO buffering parallel words ahead of the serializer.
// Ports:
//   clk, rstn        clock and asynchronous active-low reset
//   push_i, wdata_i  write request and data (ignored while full)
//   pop_i, rdata_o   read request and head-of-queue data (ignored while empty)
//   full_o, empty_o  status from the registered count
//   count_o          number of buffered entries
module nibble_serializer_sync_fifo
  import nibble_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = cnt_width(DEPTH),
  localparam int unsigned CntW = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_en, pop_en;

  always_comb begin
    full_o  = (count_q == CntW'(DEPTH));
    empty_o = (count_q == '0);
    push_en = push_i & ~full_o;
    pop_en  = pop_i & ~empty_o;
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only entries behind the count are ever read.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/nibble_serializer.sv
// Feeds a downstream WIDTH-bit shift register (shifts toward bit 0, inserts
// at bit WIDTH-1) so that after each frame it holds the accepted word.
// Ports:
//   clk, rstn             clock and asynchronous active-low reset
//   din, din_valid        parallel word and its valid
//   din_ready             FIFO not full (combinational from registered count)
//   SI, SE                registered serial data / shift enable, LSB first
//   busy                  registered: FSM active or words buffered
//   frame_done            registered one-cycle pulse after the last shift
module nibble_serializer
  import nibble_serializer_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             SI,
  output logic             SE,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BitW = cnt_width(WIDTH);
  localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
  localparam int unsigned CntW = clog2(DEPTH) + 1;
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);
  localparam logic [HoldW-1:0] LastHold = HoldW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam bit HasHold = (HOLD_CYCLES != 0);

  state_e           state_q;
  logic [BitW-1:0]  bit_cnt_q, bit_nxt;
  logic [HoldW-1:0] hold_cnt_q;
  logic [WIDTH-1:0] tx_word_q;
  logic             si_q, se_q, busy_q, frame_done_q, rst_done_q;

  logic             fifo_full, fifo_empty;
  logic [CntW-1:0]  fifo_count;
  logic [WIDTH-1:0] fifo_head;
  logic             push, pop, frame_end, hold_end;
  logic             goes_idle, cnt_next_zero, busy_d;

  nibble_serializer_sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (push),
    .wdata_i(din),
    .pop_i  (pop),
    .rdata_o(fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    // rst_done_q keeps ready low until the first edge after reset release.
    din_ready = rst_done_q & ~fifo_full;
    push      = din_valid & din_ready;
    frame_end = (state_q == StShift) && (bit_cnt_q == LastBit);
    hold_end  = (state_q == StHold) && (hold_cnt_q == LastHold);
    // A new frame may start from IDLE, straight after a frame when there is
    // no hold gap, or at the end of the hold gap.
    pop = !fifo_empty && ((state_q == StIdle) || (frame_end && !HasHold) || hold_end);
    bit_nxt = bit_cnt_q + 1'b1;
    // busy is registered, so look ahead at the post-edge state and count.
    goes_idle     = !pop && ((state_q == StIdle) || (frame_end && !HasHold) || hold_end);
    cnt_next_zero = !push && (fifo_empty || ((fifo_count == CntW'(1)) && pop));
    busy_d        = !(goes_idle && cnt_next_zero);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      tx_word_q    <= '0;
      si_q         <= 1'b0;
      se_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rst_done_q   <= 1'b0;
    end else begin
      rst_done_q   <= 1'b1;
      busy_q       <= busy_d;
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          se_q <= 1'b0;
          si_q <= 1'b0;
        end
        StShift: begin
          if (bit_cnt_q == LastBit) begin
            frame_done_q <= 1'b1;
            se_q         <= 1'b0;
            si_q         <= 1'b0;
            hold_cnt_q   <= '0;
            if (HasHold) state_q <= StHold;
            else         state_q <= StIdle;
          end else begin
            bit_cnt_q <= bit_nxt;
            se_q      <= 1'b1;
            si_q      <= tx_word_q[bit_nxt];
          end
        end
        StHold: begin
          se_q <= 1'b0;
          si_q <= 1'b0;
          if (hold_cnt_q == LastHold) state_q <= StIdle;
          else                        hold_cnt_q <= hold_cnt_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
      // Starting a frame overrides the IDLE fallback chosen above.
      if (pop) begin
        state_q   <= StShift;
        tx_word_q <= fifo_head;
        bit_cnt_q <= '0;
        se_q      <= 1'b1;
        si_q      <= fifo_head[0];
      end
    end
  end

  assign SI         = si_q;
  assign SE         = se_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: two instances (no hold gap, 3-cycle gap).
// A model of the downstream shift register is fed from SI/SE; at each
// frame_done its contents are compared with the words the bench sent.
module tb_nibble_serializer;

  logic            clk  = 1'b0;
  logic            rstn = 1'b1;
  logic [1:0][3:0] din  = '0;
  logic [1:0]      vld  = '0;
  logic [1:0]      rdy, si, se, bsy, fd;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit         se_h  [2][4096];
  bit         si_h  [2][4096];
  bit         rdy_h [2][4096];
  logic [3:0] sr    [2] = '{4'h0, 4'h0};
  int         stall [2] = '{0, 0};
  logic [3:0] dw0[$], dw1[$];
  int         dc0[$], dc1[$];
  int         acc_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serializer #(.WIDTH(4), .DEPTH(2), .HOLD_CYCLES(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .din(din[0]), .din_valid(vld[0]), .din_ready(rdy[0]),
    .SI(si[0]), .SE(se[0]), .busy(bsy[0]), .frame_done(fd[0])
  );

  nibble_serializer #(.WIDTH(4), .DEPTH(2), .HOLD_CYCLES(3)) u_dut1 (
    .clk(clk), .rstn(rstn), .din(din[1]), .din_valid(vld[1]), .din_ready(rdy[1]),
    .SI(si[1]), .SE(se[1]), .busy(bsy[1]), .frame_done(fd[1])
  );

  // Downstream register model plus per-cycle history of the serial pins.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      se_h[i][cyc[11:0]]  <= se[i];
      si_h[i][cyc[11:0]]  <= si[i];
      rdy_h[i][cyc[11:0]] <= rdy[i];
      if (!rstn) begin
        sr[i] <= 4'h0;
      end else begin
        if (fd[i]) begin
          if (i == 0) begin dw0.push_back(sr[i]); dc0.push_back(cyc); end
          else        begin dw1.push_back(sr[i]); dc1.push_back(cyc); end
        end
        if (se[i]) sr[i] <= {si[i], sr[i][3:1]};
        if (vld[i] && !rdy[i]) stall[i] <= stall[i] + 1;
      end
    end
  end

  function automatic int ndone(input int i);
    return (i == 0) ? dw0.size() : dw1.size();
  endfunction

  function automatic logic [3:0] dword(input int i, input int k);
    if (i == 0) return (k < dw0.size()) ? dw0[k] : 4'h0;
    return (k < dw1.size()) ? dw1[k] : 4'h0;
  endfunction

  function automatic int dcyc(input int i, input int k);
    if (i == 0) return (k < dc0.size()) ? dc0[k] : -1;
    return (k < dc1.size()) ? dc1[k] : -1;
  endfunction

  function automatic bit se_at(input int i, input int c);
    return se_h[i][c[11:0]];
  endfunction

  function automatic bit si_at(input int i, input int c);
    return si_h[i][c[11:0]];
  endfunction

  // Sends words on instance i, waiting out backpressure; records acceptance edges.
  task automatic send_seq(input int i, input logic [3:0] w[$], input int max_gap);
    logic got;
    acc_c.delete();
    @(posedge clk); #1;
    foreach (w[n]) begin
      din[i] = w[n];
      vld[i] = 1'b1;
      got    = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        got = rdy[i];
      end
      if (!got) begin
        errors++; checks++;
        $display("FAIL send_timeout: inst %0d word %h never accepted", i, w[n]);
      end
      acc_c.push_back(cyc + 1);
      @(posedge clk); #1;
      vld[i] = 1'b0;
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) @(posedge clk);
        #1;
      end
    end
    vld[i] = 1'b0;
  endtask

  task automatic wait_dones(input int i, input int n);
    int t = 0;
    while (ndone(i) < n && t < 400) begin @(posedge clk); t++; end
    if (ndone(i) < n) begin
      errors++; checks++;
      $display("FAIL frame_timeout: inst %0d frames %0d required %0d", i, ndone(i), n);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bsy != 2'b00) && t < 400) begin @(posedge clk); t++; end
    if (bsy != 2'b00) begin
      errors++; checks++;
      $display("FAIL idle_timeout: busy %b required 00", bsy);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    vld = '0;
    #1 rstn = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      checks++; if (si[i] !== 1'b0)  begin errors++; $display("FAIL reset_si: inst %0d got %b want 0", i, si[i]); end
      checks++; if (se[i] !== 1'b0)  begin errors++; $display("FAIL reset_se: inst %0d got %b want 0", i, se[i]); end
      checks++; if (bsy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy: inst %0d got %b want 0", i, bsy[i]); end
      checks++; if (fd[i] !== 1'b0)  begin errors++; $display("FAIL reset_done: inst %0d got %b want 0", i, fd[i]); end
      checks++; if (rdy[i] !== 1'b0) begin errors++; $display("FAIL reset_ready: inst %0d got %b want 0", i, rdy[i]); end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy !== 2'b00) begin errors++; $display("FAIL reset_ready_held: got %b want 00", rdy); end
    @(negedge clk) rstn = 1'b1;
    #1;
    checks++; if (rdy !== 2'b00) begin errors++; $display("FAIL ready_before_edge: got %b want 00", rdy); end
    @(posedge clk); #1;
    checks++; if (rdy !== 2'b11) begin errors++; $display("FAIL ready_first_edge: got %b want 11", rdy); end
    checks++; if (bsy !== 2'b00) begin errors++; $display("FAIL busy_after_reset: got %b want 00", bsy); end
  endtask

  task automatic test_single_word();
    logic [3:0] w[$];
    logic [3:0] word;
    int base, k;
    word = 4'b1011;
    w.push_back(word);
    base = ndone(0);
    send_seq(0, w, 0);
    k = acc_c[0];
    wait_dones(0, base + 1);
    checks++; if (dword(0, base) !== word) begin errors++; $display("FAIL single_word: got %h want %h", dword(0, base), word); end
    checks++; if (dcyc(0, base) != k + 5) begin errors++; $display("FAIL single_done_cycle: got %0d want %0d", dcyc(0, base), k + 5); end
    checks++; if (se_at(0, k) !== 1'b0) begin errors++; $display("FAIL single_se_pre: got 1 want 0"); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (se_at(0, k + 1 + j) !== 1'b1) begin errors++; $display("FAIL single_se bit %0d: got 0 want 1", j); end
      checks++; if (si_at(0, k + 1 + j) !== word[j]) begin errors++; $display("FAIL single_si bit %0d: got %b want %b", j, si_at(0, k + 1 + j), word[j]); end
    end
    checks++; if (se_at(0, k + 5) !== 1'b0) begin errors++; $display("FAIL single_se_post: got 1 want 0"); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w[$];
    int base, first, high;
    w.push_back(4'hA); w.push_back(4'h5); w.push_back(4'hF);
    base = ndone(0);
    send_seq(0, w, 0);
    wait_dones(0, base + 3);
    for (int n = 0; n < 3; n++) begin
      checks++; if (dword(0, base + n) !== w[n]) begin errors++; $display("FAIL b2b_word %0d: got %h want %h", n, dword(0, base + n), w[n]); end
    end
    for (int n = 1; n < 3; n++) begin
      checks++; if (dcyc(0, base + n) - dcyc(0, base + n - 1) != 4) begin
        errors++; $display("FAIL b2b_spacing %0d: got %0d want 4", n, dcyc(0, base + n) - dcyc(0, base + n - 1));
      end
    end
    checks++; if (dcyc(0, base) != acc_c[0] + 5) begin errors++; $display("FAIL b2b_first_done: got %0d want %0d", dcyc(0, base), acc_c[0] + 5); end
    first = dcyc(0, base) - 4;
    high = 0;
    for (int c = first; c < first + 12; c++) high += int'(se_at(0, c));
    checks++; if (high != 12) begin errors++; $display("FAIL b2b_se_contiguous: got %0d high cycles want 12", high); end
    checks++; if (se_at(0, first - 1) || se_at(0, first + 12)) begin
      errors++; $display("FAIL b2b_se_edges: got %b%b want 00", se_at(0, first - 1), se_at(0, first + 12));
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] w[$];
    int base, stall0;
    for (int n = 1; n <= 6; n++) w.push_back(4'(n));
    base = ndone(0);
    stall0 = stall[0];
    send_seq(0, w, 0);
    wait_dones(0, base + 6);
    checks++; if (ndone(0) != base + 6) begin errors++; $display("FAIL bp_count: got %0d frames want 6", ndone(0) - base); end
    for (int n = 0; n < 6; n++) begin
      checks++; if (dword(0, base + n) !== w[n]) begin errors++; $display("FAIL bp_order %0d: got %h want %h", n, dword(0, base + n), w[n]); end
    end
    checks++; if (stall[0] <= stall0) begin errors++; $display("FAIL bp_ready_low: got %0d stalled cycles want >0", stall[0] - stall0); end
  endtask

  task automatic test_hold_gap();
    logic [3:0] w[$];
    int base, d1, low;
    w.push_back(4'($urandom)); w.push_back(4'($urandom));
    base = ndone(1);
    send_seq(1, w, 0);
    wait_dones(1, base + 2);
    for (int n = 0; n < 2; n++) begin
      checks++; if (dword(1, base + n) !== w[n]) begin errors++; $display("FAIL hold_word %0d: got %h want %h", n, dword(1, base + n), w[n]); end
    end
    d1 = dcyc(1, base);
    checks++; if (d1 != acc_c[0] + 5) begin errors++; $display("FAIL hold_first_done: got %0d want %0d", d1, acc_c[0] + 5); end
    checks++; if (dcyc(1, base + 1) - d1 != 7) begin errors++; $display("FAIL hold_period: got %0d want 7", dcyc(1, base + 1) - d1); end
    checks++; if (se_at(1, d1 - 1) !== 1'b1) begin errors++; $display("FAIL hold_done_at_gap_start: se before done got 0 want 1"); end
    low = 0;
    for (int c = d1; c < d1 + 3; c++) low += int'(!se_at(1, c));
    checks++; if (low != 3) begin errors++; $display("FAIL hold_gap_low: got %0d low cycles want 3", low); end
    checks++; if (se_at(1, d1 + 3) !== 1'b1) begin errors++; $display("FAIL hold_gap_end: se got 0 want 1"); end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] w[$];
    logic [3:0] w9[$];
    int base, r, high;
    w.push_back(4'hC); w.push_back(4'h3);
    send_seq(0, w, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++; if ({si[0], se[0], bsy[0], fd[0], rdy[0]} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_outputs: si/se/busy/done/ready got %b want 00000", {si[0], se[0], bsy[0], fd[0], rdy[0]});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    r = cyc;
    base = ndone(0);
    repeat (12) @(posedge clk);
    high = 0;
    for (int c = r; c < r + 12; c++) high += int'(se_at(0, c));
    checks++; if (high != 0) begin errors++; $display("FAIL mid_reset_no_se: got %0d SE cycles want 0", high); end
    checks++; if (ndone(0) != base) begin errors++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", ndone(0) - base); end
    w9.push_back(4'h9);
    send_seq(0, w9, 0);
    wait_dones(0, base + 1);
    checks++; if (dword(0, base) !== 4'h9) begin errors++; $display("FAIL mid_reset_next_word: got %h want 9", dword(0, base)); end
    checks++; if (dcyc(0, base) != acc_c[0] + 5) begin errors++; $display("FAIL mid_reset_next_timing: got %0d want %0d", dcyc(0, base), acc_c[0] + 5); end
  endtask

  task automatic test_simultaneous_push_pop();
    logic [3:0] w[$];
    int base, k;
    w.push_back(4'($urandom)); w.push_back(4'($urandom));
    base = ndone(0);
    send_seq(0, w, 0);
    k = acc_c[0];
    wait_dones(0, base + 2);
    checks++; if (acc_c[1] != k + 1) begin errors++; $display("FAIL simul_accept_edge: got %0d want %0d", acc_c[1], k + 1); end
    checks++; if (!rdy_h[0][12'(k + 1)] || !rdy_h[0][12'(k + 2)]) begin
      errors++; $display("FAIL simul_ready: got %b%b want 11", rdy_h[0][12'(k + 1)], rdy_h[0][12'(k + 2)]);
    end
    for (int n = 0; n < 2; n++) begin
      checks++; if (dword(0, base + n) !== w[n]) begin errors++; $display("FAIL simul_order %0d: got %h want %h", n, dword(0, base + n), w[n]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] w[$];
      int base, period;
      period = (i == 0) ? 4 : 7;
      for (int n = 0; n < 10; n++) w.push_back(4'($urandom));
      base = ndone(i);
      send_seq(i, w, 3);
      wait_dones(i, base + 10);
      for (int n = 0; n < 10; n++) begin
        checks++; if (dword(i, base + n) !== w[n]) begin
          errors++; $display("FAIL random_word inst %0d #%0d: got %h want %h", i, n, dword(i, base + n), w[n]);
        end
        if (n > 0) begin
          checks++; if (dcyc(i, base + n) - dcyc(i, base + n - 1) < period) begin
            errors++; $display("FAIL random_spacing inst %0d #%0d: got %0d want >=%0d", i, n, dcyc(i, base + n) - dcyc(i, base + n - 1), period);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    wait_idle();
    test_single_word();
    wait_idle();
    test_back_to_back();
    wait_idle();
    test_backpressure();
    wait_idle();
    test_hold_gap();
    wait_idle();
    test_reset_mid_frame();
    wait_idle();
    test_simultaneous_push_pop();
    wait_idle();
    test_random();
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

Upstream feeder for the 4-bit serial shift register stage. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. It then drives the downstream serial-in (SI) and shift-enable (SE) pins so that, after each frame, the downstream register holds the accepted word exactly. It also produces a frame-done strobe so the consumer knows when the downstream parallel contents are valid.

## Interface
- WIDTH, 4: word width; equals the downstream shift-register length.
- DEPTH, 2: input FIFO entries; power of two, ≥2.
- HOLD_CYCLES, 1: idle cycles (SE low) after each frame before the next frame starts; 0 allowed.
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous, active-low reset; shared with the downstream register.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  FIFO can accept; a transfer occurs on a rising edge with din_valid & din_ready.
- SI  output  1  serial data to downstream; registered.
- SE  output  1  shift enable to downstream; registered.
- busy  output  1  FSM not in IDLE, or FIFO not empty.
- frame_done  output  1  one-cycle pulse; the downstream register holds the completed word.

## Operation
- Downstream shifts toward bit 0 and inserts SI at bit WIDTH-1, so bits are sent LSB first: din[0] first, din[WIDTH-1] last.
- After WIDTH SE-high cycles, downstream shift_reg equals din.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - FIFO non-empty: pop the head into tx_word, set bit_cnt=0, go to SHIFT.
  - Otherwise SE=0, SI=0.
- SHIFT: SE=1, SI=tx_word[bit_cnt]. bit_cnt increments each cycle. When bit_cnt==WIDTH-1:
  - HOLD_CYCLES>0: go to HOLD with hold_cnt=0.
  - HOLD_CYCLES==0 and FIFO non-empty: pop the next word and stay in SHIFT with bit_cnt=0 (back-to-back frames).
  - Otherwise: go to IDLE.
- HOLD: SE=0, SI=0. When hold_cnt==HOLD_CYCLES-1, apply the same pop-or-IDLE decision as the end of SHIFT.
- frame_done pulses in the cycle after the last SE-high cycle of each frame.
- din_ready = !fifo_full, derived from registered FIFO count only.
  - No same-cycle pass-through from a pop to ready.
  - A push into a full FIFO cannot occur.
- Push and pop on the same edge with the FIFO non-empty and not full: count is unchanged, data order preserved.
- FIFO pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- din_valid while din_ready=0: din is ignored; the upstream source must hold it.
- Reset values (asynchronous, immediate on rstn low): SI=0, SE=0, frame_done=0, busy=0, din_ready=0 while rstn is low, FIFO empty, FSM=IDLE, counters=0.
- After rstn deasserts, din_ready=1 from the first edge.
- Reset mid-frame: the partial frame and all buffered words are discarded. No frame_done is produced for them.

## Timing
- Word accepted at edge k with FIFO empty and FSM in IDLE:
  - Pop at edge k+1; SE/SI are high with bit 0 during cycle k+1.
  - Downstream captures bit i at edge k+2+i.
  - Last SE-high cycle is k+WIDTH.
  - frame_done is high in cycle k+WIDTH+1.
- Frame period: WIDTH+HOLD_CYCLES cycles with the FIFO non-empty. With HOLD_CYCLES=0, SE stays continuously high across frames.
- IDLE costs one cycle between an empty FIFO becoming non-empty and the first SE.
- All outputs except din_ready are registered.

## Structure
- Shared package/header: FSM state encodings (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2) and the clog2 helper.
- One sub-module, sync_fifo: parameters WIDTH and DEPTH; ports push/pop/full/empty/count, same clk/rstn.
- Top level: FSM, bit_cnt, hold_cnt, tx_word, output registers.

## Test plan
- Reset then single word: din=4'b1011 → SE high for 4 cycles with SI sequence 1,1,0,1, frame_done one cycle later, model shift_reg=4'b1011.
- Back-to-back with HOLD_CYCLES=0: push 4'hA, 4'h5, 4'hF consecutively → SE high for 12 contiguous cycles, three frame_done pulses 4 cycles apart, model register holds A, 5, F at each pulse.
- FIFO full / backpressure, DEPTH=2: din_valid held high with 4'h1..4'h6 → din_ready low while 2 entries are buffered, no word lost or duplicated, output order 1..6.
- HOLD_CYCLES=3 spacing: two words queued → SE low for exactly 3 cycles between frames; frame_done is present at the start of the gap.
- Reset mid-frame: assert rstn low after 2 shifts of 4'hC with 4'h3 queued → SI=SE=busy=0 immediately. After release there is no SE and no frame_done until a new push; a subsequent 4'h9 serializes correctly.
- Simultaneous push and pop with the FIFO at count 1 → count stays 1, order preserved, din_ready stays 1.
